// File: rtl/lab2_proc_mem_arbiter.sv
// Shares one memory port between imem and dmem val/rdy streams; round-robin grant
// (strict dmem priority when LAB2_PROC_MEM_ARB_FIXED_PRIO_EN is defined).
// Zero-latency combinational paths; requests stall while the order queue is full.

package lab2_mem_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

module lab2_proc_mem_arbiter
  import lab2_mem_pkg::*;
#(
  parameter int p_num_outstanding = 4
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         imem_reqstream_val,
  output logic         imem_reqstream_rdy,
  input  mem_req_4B_t  imem_reqstream_msg,

  output logic         imem_respstream_val,
  input  logic         imem_respstream_rdy,
  output mem_resp_4B_t imem_respstream_msg,

  input  logic         dmem_reqstream_val,
  output logic         dmem_reqstream_rdy,
  input  mem_req_4B_t  dmem_reqstream_msg,

  output logic         dmem_respstream_val,
  input  logic         dmem_respstream_rdy,
  output mem_resp_4B_t dmem_respstream_msg,

  output logic         mem_reqstream_val,
  input  logic         mem_reqstream_rdy,
  output mem_req_4B_t  mem_reqstream_msg,

  input  logic         mem_respstream_val,
  output logic         mem_respstream_rdy,
  input  mem_resp_4B_t mem_respstream_msg
);

  localparam int c_ptr_w = (p_num_outstanding > 1) ? $clog2(p_num_outstanding) : 1;
  localparam int c_cnt_w = $clog2(p_num_outstanding) + 1;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(p_num_outstanding);

  // Order queue: one bit per in-flight request, 0 = imem, 1 = dmem.
  logic [p_num_outstanding-1:0] r_order;
  logic [c_ptr_w-1:0]           r_head;
  logic [c_ptr_w-1:0]           r_tail;
  logic [c_cnt_w-1:0]           r_count;
`ifndef LAB2_PROC_MEM_ARB_FIXED_PRIO_EN
  logic                         r_last_grant;
`endif

  logic w_full;
  logic w_empty;
  logic w_grant_vld;
  logic w_grant_id;
  logic w_req_ok;
  logic w_resp_ok;
  logic w_head_id;
  logic w_mem_req_val;
  logic w_mem_resp_rdy;
  logic w_push;
  logic w_pop;

  assign w_full    = (r_count == c_full_cnt);
  assign w_empty   = (r_count == '0);
  assign w_head_id = r_order[r_head];
  assign w_req_ok  = !reset && !w_full;
  assign w_resp_ok = !reset && !w_empty;

  always_comb begin
    w_grant_vld = imem_reqstream_val || dmem_reqstream_val;
`ifdef LAB2_PROC_MEM_ARB_FIXED_PRIO_EN
    w_grant_id  = dmem_reqstream_val;
`else
    // On a tie the port that did not win last time is served.
    if (imem_reqstream_val && dmem_reqstream_val)
      w_grant_id = ~r_last_grant;
    else
      w_grant_id = dmem_reqstream_val;
`endif
  end

  always_comb begin
    w_mem_req_val      = w_req_ok && w_grant_vld;
    imem_reqstream_rdy = w_req_ok && w_grant_vld && !w_grant_id && mem_reqstream_rdy;
    dmem_reqstream_rdy = w_req_ok && w_grant_vld &&  w_grant_id && mem_reqstream_rdy;
    mem_reqstream_msg  = '0;
    if (!reset && w_grant_vld)
      mem_reqstream_msg = w_grant_id ? dmem_reqstream_msg : imem_reqstream_msg;
  end

  assign mem_reqstream_val = w_mem_req_val;

  always_comb begin
    imem_respstream_val = w_resp_ok && !w_head_id && mem_respstream_val;
    dmem_respstream_val = w_resp_ok &&  w_head_id && mem_respstream_val;
    w_mem_resp_rdy      = w_resp_ok && (w_head_id ? dmem_respstream_rdy : imem_respstream_rdy);
    imem_respstream_msg = reset ? '0 : mem_respstream_msg;
    dmem_respstream_msg = reset ? '0 : mem_respstream_msg;
  end

  assign mem_respstream_rdy = w_mem_resp_rdy;

  assign w_push = w_mem_req_val && mem_reqstream_rdy;
  assign w_pop  = mem_respstream_val && w_mem_resp_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_order <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_order[r_tail] <= w_grant_id;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop)
        r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef LAB2_PROC_MEM_ARB_FIXED_PRIO_EN
  // Only a fired request moves the grant, so a stalled grant stays put.
  always_ff @(posedge clk) begin
    if (reset)
      r_last_grant <= 1'b0;
    else if (w_push)
      r_last_grant <= w_grant_id;
  end
`endif

endmodule

// File: doc/lab2_proc_mem_arbiter.md
# lab2_proc_mem_arbiter

Two-to-one memory port arbiter that lets the processor's instruction-fetch and data-memory request/response streams share a single memory port. Both requests use val/rdy handshakes. It sits between the pipelined processor (imem and dmem ports) and a single-ported cache or test memory. It arbitrates requests round-robin and records the issuing port of every outstanding request in an order queue. Each returning response is routed to the port at the head of that queue.

## Interface
Parameters:
- p_num_outstanding, default 4: order-queue depth; maximum in-flight requests; power of two, ≥ 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- imem_reqstream_val / _rdy / _msg  input / output / input  1 / 1 / mem_req_4B_t  fetch request stream
- imem_respstream_val / _rdy / _msg  output / input / output  1 / 1 / mem_resp_4B_t  fetch response stream
- dmem_reqstream_val / _rdy / _msg  input / output / input  1 / 1 / mem_req_4B_t  data request stream
- dmem_respstream_val / _rdy / _msg  output / input / output  1 / 1 / mem_resp_4B_t  data response stream
- mem_reqstream_val / _rdy / _msg  output / input / output  1 / 1 / mem_req_4B_t  shared memory request
- mem_respstream_val / _rdy / _msg  input / output / input  1 / 1 / mem_resp_4B_t  shared memory response

## Operation
- State:
  - last_grant: 1 bit; 0 = imem, 1 = dmem.
  - Order queue: p_num_outstanding × 1 bit, with head/tail pointers and a count of width $clog2(p_num_outstanding)+1.
- Grant:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to last_grant is granted.
  - Neither requesting: no grant.
- Request path:
  - mem_reqstream_val = granted port's val && !full.
  - mem_reqstream_msg = granted port's msg, unmodified; it is 0 when there is no grant.
  - Granted port's rdy = mem_reqstream_rdy && !full. The non-granted port's rdy = 0.
- Request fire (mem_reqstream_val && mem_reqstream_rdy):
  - Push the granted port id at tail.
  - Update last_grant to the granted port.
  - last_grant changes only on fire.
- Response path:
  - Memory returns responses strictly in request order.
  - If the queue is empty, all response vals are 0 and mem_respstream_rdy = 0.
  - Otherwise the head id selects the destination port: destination val = mem_respstream_val, the other port's val = 0, and mem_respstream_rdy = destination rdy.
  - Both response msgs always equal mem_respstream_msg.
- Response fire: pop the head.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo p_num_outstanding.
- Full (count == p_num_outstanding): all request rdy outputs and mem_reqstream_val are forced to 0, even if a pop occurs in the same cycle. Pushing resumes the following cycle.
- A response arriving while the queue is empty is never accepted, because mem_respstream_rdy = 0.

## Timing
- Request and response paths are combinational, with zero added latency.
- The queue and last_grant update at the clk posedge.
- No output val depends combinationally on its own rdy.
- Reset (synchronous; also valid mid-transaction):
  - Queue empty: count = 0, head = tail = 0.
  - last_grant = 0, so dmem wins the first tie.
  - All outputs in the reset cycle: vals = 0, rdys = 0, msgs = 0.
  - In-flight responses are dropped.
- Requesters are val/rdy compliant: val and msg are held until fire. The grant therefore stays stable while memory stalls, because last_grant does not change.
- Throughput: one request and one response per cycle.

## Configuration
- LAB2_PROC_MEM_ARB_FIXED_PRIO_EN:
  - Defined: dmem has strict priority whenever dmem_reqstream_val = 1, and last_grant is unused.
  - Undefined (default): round-robin as specified under Operation.
- Queue behaviour is identical in both builds.

## Test plan
- Single fetch stream:
  - Stimulus: imem requests addr 0x200, 0x204, 0x208 with mem_reqstream_rdy = 1.
  - Response: three mem requests in that order; the three responses appear only on imem_respstream, in order, with dmem_respstream_val = 0 throughout.
- Tie with round-robin:
  - Stimulus: both ports valid for 4 consecutive cycles.
  - Response: grant order is dmem, imem, dmem, imem.
  - Same stimulus with LAB2_PROC_MEM_ARB_FIXED_PRIO_EN defined: dmem is granted all 4 cycles.
- Full queue:
  - Stimulus: p_num_outstanding = 4, 4 requests issued, no responses returned.
  - Response: the 5th request sees rdy = 0.
  - On pop the cycle after, the 5th request fires one cycle after the pop, never in the same cycle.
- Response backpressure:
  - Stimulus: head = dmem and dmem_respstream_rdy = 0 for 3 cycles.
  - Response: mem_respstream_rdy = 0 for those 3 cycles; the queue is unchanged; imem_respstream_val stays 0.
- Memory stall grant stability:
  - Stimulus: mem_reqstream_rdy = 0 for 5 cycles with both ports valid.
  - Response: the granted port and mem_reqstream_msg stay constant; last_grant is unchanged.
- Reset mid-flight:
  - Stimulus: 2 requests outstanding, then reset asserted for 1 cycle.
  - Response: count = 0; a stray mem response afterwards is not accepted (mem_respstream_rdy = 0).
